// File: rtl/stack_alu_ctrl.sv
// Stack ALU sequencer: pops two operands, applies cmd_op, pushes the result (STACK_ALU_SATURATE_EN saturates overflowed results).
// Latency: 7 cycles acceptance-to-done on success, 1 on illegal/empty, 4 on second-operand underflow.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored in every other state.
module stack_alu_ctrl #(
    parameter int DATA_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [2:0]          cmd_op,
    output logic                cmd_ready,
    output logic                stk_pop,
    output logic                stk_push,
    output logic [DATA_LEN-1:0] stk_data_in,
    input  logic [DATA_LEN-1:0] stk_data_out,
    input  logic                stk_empty,
    output logic                done,
    output logic [DATA_LEN-1:0] res_out,
    output logic                err,
    output logic                ovf
);

    localparam int WIDE = 2 * DATA_LEN;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

`ifdef STACK_ALU_SATURATE_EN
    localparam logic [DATA_LEN-1:0] SAT_MAX = {1'b0, {(DATA_LEN-1){1'b1}}};
    localparam logic [DATA_LEN-1:0] SAT_MIN = {1'b1, {(DATA_LEN-1){1'b0}}};
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_POP1,
        S_RCV1,
        S_POP2,
        S_RCV2,
        S_EXEC,
        S_PUSH,
        S_RESTORE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [DATA_LEN-1:0] r_op1;
    logic [DATA_LEN-1:0] r_op2;
    logic [DATA_LEN-1:0] r_res;
    logic                r_res_ovf;
    logic                r_cmd_ready;
    logic                r_stk_pop;
    logic                r_stk_push;
    logic [DATA_LEN-1:0] r_stk_data_in;
    logic                r_done;
    logic [DATA_LEN-1:0] r_res_out;
    logic                r_err;
    logic                r_ovf;

    logic                w_legal;
    logic [WIDE-1:0]     w_a;
    logic [WIDE-1:0]     w_b;
    logic [WIDE-1:0]     w_wide;
    logic                w_arith;
    logic                w_ovf;
    logic [DATA_LEN-1:0] w_res;

    assign w_legal = (cmd_op <= OP_MUL);
    assign w_a     = {{DATA_LEN{r_op1[DATA_LEN-1]}}, r_op1};
    assign w_b     = {{DATA_LEN{r_op2[DATA_LEN-1]}}, r_op2};

    // Double-width arithmetic holds the exact ADD/SUB/MUL result, so overflow
    // is simply "the wide value is not the sign extension of its low half".
    always_comb begin
        w_wide  = '0;
        w_arith = 1'b0;
        w_res   = '0;
        case (r_op)
            OP_ADD: begin
                w_wide  = w_a + w_b;
                w_arith = 1'b1;
            end
            OP_SUB: begin
                w_wide  = w_a - w_b;
                w_arith = 1'b1;
            end
            OP_MUL: begin
                w_wide  = $signed(w_a) * $signed(w_b);
                w_arith = 1'b1;
            end
            OP_AND:  w_res = r_op1 & r_op2;
            OP_OR:   w_res = r_op1 | r_op2;
            OP_XOR:  w_res = r_op1 ^ r_op2;
            default: w_res = '0;
        endcase
        w_ovf = w_arith &&
                (w_wide != {{DATA_LEN{w_wide[DATA_LEN-1]}}, w_wide[DATA_LEN-1:0]});
        if (w_arith) begin
            w_res = w_wide[DATA_LEN-1:0];
        end
`ifdef STACK_ALU_SATURATE_EN
        if (w_ovf) begin
            w_res = w_wide[WIDE-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_res         <= '0;
            r_res_ovf     <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_stk_pop     <= 1'b0;
            r_stk_push    <= 1'b0;
            r_stk_data_in <= '0;
            r_done        <= 1'b0;
            r_res_out     <= '0;
            r_err         <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            // Strobes are decoded one state ahead so they are registered in their own state.
            r_stk_pop     <= 1'b0;
            r_stk_push    <= 1'b0;
            r_stk_data_in <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_ovf         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_cmd_ready <= 1'b0;
                        if (!w_legal || stk_empty) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state   <= S_POP1;
                            r_stk_pop <= 1'b1;
                        end
                    end
                end
                S_POP1: r_state <= S_RCV1;
                S_RCV1: begin
                    r_op1 <= stk_data_out;
                    if (!stk_empty) begin
                        r_state   <= S_POP2;
                        r_stk_pop <= 1'b1;
                    end else begin
                        r_state       <= S_RESTORE;
                        r_stk_push    <= 1'b1;
                        r_stk_data_in <= stk_data_out;
                    end
                end
                S_POP2: r_state <= S_RCV2;
                S_RCV2: begin
                    r_op2   <= stk_data_out;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_res         <= w_res;
                    r_res_ovf     <= w_ovf;
                    r_state       <= S_PUSH;
                    r_stk_push    <= 1'b1;
                    r_stk_data_in <= w_res;
                end
                S_PUSH: begin
                    r_state   <= S_DONE;
                    r_done    <= 1'b1;
                    r_ovf     <= r_res_ovf;
                    r_res_out <= r_res;
                end
                S_RESTORE: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_err   <= 1'b1;
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign stk_pop     = r_stk_pop;
    assign stk_push    = r_stk_push;
    assign stk_data_in = r_stk_data_in;
    assign done        = r_done;
    assign res_out     = r_res_out;
    assign err         = r_err;
    assign ovf         = r_ovf;

endmodule
